// File: rtl/rand_defs_pkg.sv
// Shared definitions for the entropy conditioning blocks: default word width,
// pair-state encoding and the drop counter width.
package rand_defs;
  localparam int WS_DEF = 16;
  localparam int DROP_W = 8;

  typedef enum logic {
    P_EMPTY = 1'b0,
    P_HAVE  = 1'b1
  } pair_st_e;
endpackage

// File: rtl/rand_fifo.sv
// First-word-fall-through FIFO. A push while full is accepted only when a pop
// frees a slot in the same cycle; otherwise it is silently ignored.
module rand_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, rd_q;
  logic         do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end
endmodule

// File: rtl/rand_vn_debias.sv
// Von Neumann debiaser with LSB-first word packer, output FIFO and a
// repetition-count health test that freezes conditioning on a stuck source.
module rand_vn_debias
  import rand_defs::*;
#(
  parameter int ws      = WS_DEF,
  parameter int DEPTH   = 4,
  parameter int RCT_LIM = 32
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iIn,
  input  logic              iInValid,
  output logic [ws-1:0]     oOut,
  output logic              oValid,
  input  logic              iReady,
  output logic              oFault,
  output logic [DROP_W-1:0] oDropCnt
);
  localparam int            BW   = $clog2(ws);
  localparam logic [BW-1:0] LAST = BW'(ws - 1);
  localparam logic [7:0]    LIM  = 8'(RCT_LIM);

  pair_st_e          st_q, st_d;
  logic              a_q, a_d;
  logic [ws-1:0]     word_q, word_d, word_full;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic              prev_q, prev_d, seen_q, seen_d;
  logic [7:0]        rct_q, rct_d;
  logic              fault_q, fault_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              smp, trip, take, emit, push, pop;
  logic              f_full, f_empty;
  logic [ws-1:0]     f_head;

  // Health test: the sample that completes the run trips the fault and is
  // withheld from the debiaser.
  always_comb begin
    smp     = iInValid && !fault_q;
    rct_d   = rct_q;
    prev_d  = prev_q;
    seen_d  = seen_q;
    fault_d = fault_q;
    trip    = 1'b0;
    if (smp) begin
      rct_d  = (seen_q && (iIn == prev_q)) ? rct_q + 8'd1 : 8'd1;
      prev_d = iIn;
      seen_d = 1'b1;
      if (rct_d == LIM) begin
        trip    = 1'b1;
        fault_d = 1'b1;
      end
    end
  end

  assign take = smp && !trip;

  always_ff @(posedge iCLK) begin
    if (iRST) st_q <= P_EMPTY;
    else      st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    if (trip)      st_d = P_EMPTY;
    else if (take) st_d = (st_q == P_EMPTY) ? P_HAVE : P_EMPTY;
  end

  always_comb begin
    emit = 1'b0;
    a_d  = a_q;
    if (take) begin
      if (st_q == P_EMPTY) a_d = iIn;
      else                 emit = (iIn != a_q);
    end
  end

  always_comb begin
    word_full         = word_q;
    word_full[bcnt_q] = a_q;
    word_d            = word_q;
    bcnt_d            = bcnt_q;
    push              = 1'b0;
    if (trip) begin
      word_d = '0;
      bcnt_d = '0;
    end else if (emit) begin
      if (bcnt_q == LAST) begin
        push   = 1'b1;
        word_d = '0;
        bcnt_d = '0;
      end else begin
        word_d = word_full;
        bcnt_d = bcnt_q + BW'(1);
      end
    end
  end

  assign pop = !f_empty && iReady;

  always_comb begin
    drop_d = drop_q;
    if (push && f_full && !pop && (drop_q != '1)) drop_d = drop_q + DROP_W'(1);
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      a_q     <= 1'b0;
      word_q  <= '0;
      bcnt_q  <= '0;
      prev_q  <= 1'b0;
      seen_q  <= 1'b0;
      rct_q   <= '0;
      fault_q <= 1'b0;
      drop_q  <= '0;
    end else begin
      a_q     <= a_d;
      word_q  <= word_d;
      bcnt_q  <= bcnt_d;
      prev_q  <= prev_d;
      seen_q  <= seen_d;
      rct_q   <= rct_d;
      fault_q <= fault_d;
      drop_q  <= drop_d;
    end
  end

  rand_fifo #(.W(ws), .DEPTH(DEPTH)) u_fifo (
    .clk_i  (iCLK),
    .rst_i  (iRST),
    .push_i (push),
    .din_i  (word_full),
    .pop_i  (pop),
    .head_o (f_head),
    .full_o (f_full),
    .empty_o(f_empty)
  );

  assign oValid   = !f_empty;
  assign oOut     = f_empty ? '0 : f_head;
  assign oFault   = fault_q;
  assign oDropCnt = drop_q;
endmodule

// File: tb/tb_rand_vn_debias.sv
// Bench for rand_vn_debias: directed vector table, hand sequences for
// backpressure/fault corners, and randomized traffic against a queue model.
module tb_rand_vn_debias;
  localparam int WS = 16, DEPTH = 4, RCT_LIM = 32;

  logic          clk = 0, rst = 1, in_b = 0, in_v = 0, rdy = 0;
  logic [WS-1:0] out_w;
  logic          out_v, fault;
  logic [7:0]    dcnt;
  int            nchk = 0, nerr = 0;

  always #5 clk = ~clk;

  rand_vn_debias #(.ws(WS), .DEPTH(DEPTH), .RCT_LIM(RCT_LIM)) dut (
    .iCLK(clk), .iRST(rst), .iIn(in_b), .iInValid(in_v),
    .oOut(out_w), .oValid(out_v), .iReady(rdy),
    .oFault(fault), .oDropCnt(dcnt)
  );

  // Reference model: raw history, pending pair and emitted bits as queues.
  logic [WS-1:0] mq[$];
  bit            hist[$], pend[$], bits[$];
  bit            m_fault;
  int            m_drop, run;
  logic [WS-1:0] w;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete(); hist.delete(); pend.delete(); bits.delete();
      m_fault = 0; m_drop = 0;
    end else begin
      if (mq.size() != 0 && rdy) void'(mq.pop_front());
      if (in_v && !m_fault) begin
        hist.push_back(in_b);
        if (hist.size() > 300) void'(hist.pop_front());
        run = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
          if (hist[i] != in_b) break;
          run++;
        end
        if (run >= RCT_LIM) begin
          m_fault = 1; pend.delete(); bits.delete();
        end else begin
          pend.push_back(in_b);
          if (pend.size() == 2) begin
            if (pend[0] != pend[1]) bits.push_back(pend[0]);
            pend.delete();
          end
          if (bits.size() == WS) begin
            w = '0;
            for (int i = 0; i < WS; i++) w[i] = bits[i];
            bits.delete();
            if (mq.size() < DEPTH) mq.push_back(w);
            else if (m_drop < 255) m_drop++;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    chk("m_valid", 32'(out_v), 32'(mq.size() != 0));
    chk("m_out",   32'(out_w), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
    chk("m_fault", 32'(fault), 32'(m_fault));
    chk("m_drop",  32'(dcnt),  32'(m_drop));
  endtask

  task automatic smp(input bit b);
    in_v = 1; in_b = b; tick(); in_v = 0;
  endtask

  task automatic pair(input bit a, input bit b);
    smp(a); smp(b);
  endtask

  task automatic idle(input int n);
    in_v = 0;
    repeat (n) tick();
  endtask

  task automatic word(input logic [15:0] wd, input bit rdy_last);
    for (int k = 0; k < 16; k++) begin
      smp(wd[k]);
      if (k == 15) rdy = rdy_last;
      smp(!wd[k]);
      rdy = 0;
    end
  endtask

  task automatic pop_exp(input string nm, input logic [15:0] e);
    chk({nm, "_v"}, 32'(out_v), 32'd1);
    chk(nm, 32'(out_w), 32'(e));
    rdy = 1; tick(); rdy = 0;
  endtask

  typedef struct {
    logic [15:0] pat;
    bit          disc;
    bit          gaps;
    bit          rst_mid;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl[5];
  int   bias;

  initial begin
    tbl[0] = '{16'hFFFF, 0, 0, 0, 16'hFFFF};
    tbl[1] = '{16'h5555, 1, 1, 0, 16'h5555};
    tbl[2] = '{16'h0000, 0, 0, 1, 16'h0000};
    tbl[3] = '{16'hA3C5, 1, 0, 0, 16'hA3C5};
    tbl[4] = '{16'h8001, 0, 1, 1, 16'h8001};

    // Reset defaults with random inputs
    rst = 1;
    repeat (2) begin
      in_b = 1'($urandom); in_v = 1'($urandom); rdy = 1'($urandom);
      tick();
    end
    chk("rst_valid", 32'(out_v), 0);
    chk("rst_out",   32'(out_w), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_drop",  32'(dcnt),  0);
    rst = 0; in_v = 0; rdy = 0;
    idle(1);

    // Directed vector table
    for (int t = 0; t < 5; t++) begin
      if (tbl[t].rst_mid) begin
        for (int k = 0; k < 8; k++) pair(1, 0);
        rst = 1; tick(); rst = 0;
      end
      for (int k = 0; k < 16; k++) begin
        smp(tbl[t].pat[k]);
        if (k == 15) chk("tbl_pre_valid", 32'(out_v), 0);
        smp(!tbl[t].pat[k]);
        if (tbl[t].disc && k < 15) pair(k % 2 == 1, k % 2 == 1);
        if (tbl[t].gaps && k % 3 == 0) idle(2);
      end
      chk("tbl_valid", 32'(out_v), 1);
      chk("tbl_word",  32'(out_w), 32'(tbl[t].exp));
      rdy = 1; tick(); rdy = 0;
      chk("tbl_single", 32'(out_v), 0);
    end

    // Backpressure, drop on full, and push+pop while full
    word(16'hFFFF, 0); word(16'h0000, 0); word(16'hFFFF, 0); word(16'h0000, 0);
    chk("bp_nodrop", 32'(dcnt), 0);
    word(16'hFFFF, 0);
    chk("bp_drop", 32'(dcnt), 1);
    word(16'hA5A5, 1);
    chk("bp_fullpop_nodrop", 32'(dcnt), 1);
    pop_exp("bp_d1", 16'h0000);
    pop_exp("bp_d2", 16'hFFFF);
    pop_exp("bp_d3", 16'h0000);
    pop_exp("bp_d4", 16'hA5A5);
    chk("bp_empty", 32'(out_v), 0);

    // Health fault
    rst = 1; tick(); rst = 0;
    word(16'h9234, 0);
    for (int k = 0; k < 4; k++) pair(1, 0);
    for (int k = 0; k < 31; k++) smp(1);
    chk("flt_pre", 32'(fault), 0);
    smp(1);
    chk("flt_set", 32'(fault), 1);
    for (int k = 0; k < 32; k++) pair(1, 0);
    chk("flt_sticky", 32'(fault), 1);
    pop_exp("flt_drain", 16'h9234);
    chk("flt_nonew", 32'(out_v), 0);
    rst = 1; tick(); rst = 0;
    chk("flt_clr", 32'(fault), 0);
    word(16'h00FF, 0);
    pop_exp("flt_after", 16'h00FF);

    // Randomized traffic; the late high-bias phase drives the health test
    for (int c = 0; c < 4000; c++) begin
      bias = (c < 3000) ? 60 : 97;
      in_v = ($urandom_range(0, 3) != 0);
      in_b = ($urandom_range(0, 99) < bias);
      rdy  = ($urandom_range(0, 2) == 0);
      rst  = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst = 0; in_v = 0; rdy = 1;
    idle(DEPTH + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end
endmodule
